start_bit_det_multi: RTL and testbench

- Parametrised, multi-channel successor of the single-line start bit detector.
- Each channel has:
  - a configurable-depth synchroniser;
  - a consecutive-sample glitch filter;
  - a selectable edge-detect mode (falling/rising/both);
  - an arm/fire state machine, so one start bit yields exactly one pulse until the downstream receiver re-arms the channel.
- Sits between raw serial pins and the per-channel receiver controllers.

---
 rtl/start_bit_det_multi.sv | 148 ++++++++++++++
 tb/tb_start_bit_det_multi.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/start_bit_det_multi.sv
// Multi-channel start bit detector.
// Each channel synchronises a raw serial line, rejects glitches shorter than
// FILT_LEN synchronised samples, then picks out falling/rising/both edges of
// the filtered level. An arm/fire FSM makes sure one start bit gives one pulse
// until the downstream receiver re-arms the channel.
//
// Ports:
//   clk                 system clock, all state on rising edge
//   n_rst               asynchronous active-low reset
//   serial_in[NUM_CH]   raw asynchronous serial lines, bit i = channel i
//   enable              global detect enable (filter frozen when low)
//   mode[1:0]           00 falling, 01 rising, 10 both, 11 off
//   rearm[NUM_CH]       one-cycle pulse, returns channel i to ARMED
//   start_bit_detected  registered one-cycle pulse per qualifying edge
//   filt_level          registered filtered line level
//   armed               1 = channel in ARMED state

module start_bit_det_lane #(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILT_LEN    = 3,
  parameter logic IDLE_VAL    = 1'b1
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       serial_in,
  input  logic       enable,
  input  logic [1:0] mode,
  input  logic       rearm,
  output logic       pulse,
  output logic       filt_level,
  output logic       armed
);
  localparam int CW = $clog2(FILT_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

  typedef enum logic {ARMED, FIRED} state_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   pulse_q, pulse_d;
  state_e                 state_q, state_d;
  logic                   sync_out, flip, qual, armed_now;

  assign sync_out = sync_q[SYNC_STAGES-1];
  // Level flips once the mismatch has been seen FILT_LEN samples in a row.
  assign flip     = enable && (sync_out != filt_q) && (cnt_q == CNT_LAST);

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], serial_in};
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (!enable || sync_out == filt_q) begin
      cnt_d = '0;
    end else if (flip) begin
      cnt_d  = '0;
      filt_d = ~filt_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // filt_q still holds the old level on a flip: 1 means a falling edge.
  always_comb begin
    qual = 1'b0;
    if (flip) begin
      case (mode)
        2'b00:   qual = filt_q;
        2'b01:   qual = ~filt_q;
        2'b10:   qual = 1'b1;
        default: qual = 1'b0;
      endcase
    end
  end

  // rearm is applied before the edge, so a coincident rearm + edge fires.
  always_comb begin
    armed_now = rearm || (state_q == ARMED);
    state_d   = armed_now ? ARMED : FIRED;
    pulse_d   = 1'b0;
    if (armed_now && qual) begin
      pulse_d = 1'b1;
      state_d = FIRED;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q  <= {SYNC_STAGES{IDLE_VAL}};
      cnt_q   <= '0;
      filt_q  <= IDLE_VAL;
      pulse_q <= 1'b0;
      state_q <= ARMED;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      filt_q  <= filt_d;
      pulse_q <= pulse_d;
      state_q <= state_d;
    end
  end

  assign pulse      = pulse_q;
  assign filt_level = filt_q;
  assign armed      = (state_q == ARMED);
endmodule

module start_bit_det_multi #(
  parameter int   NUM_CH      = 4,
  parameter int   SYNC_STAGES = 2,
  parameter int   FILT_LEN    = 3,
  parameter logic IDLE_VAL    = 1'b1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [NUM_CH-1:0] serial_in,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [NUM_CH-1:0] rearm,
  output logic [NUM_CH-1:0] start_bit_detected,
  output logic [NUM_CH-1:0] filt_level,
  output logic [NUM_CH-1:0] armed
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    start_bit_det_lane #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_LEN   (FILT_LEN),
      .IDLE_VAL   (IDLE_VAL)
    ) u_lane (
      .clk       (clk),
      .n_rst     (n_rst),
      .serial_in (serial_in[i]),
      .enable    (enable),
      .mode      (mode),
      .rearm     (rearm[i]),
      .pulse     (start_bit_detected[i]),
      .filt_level(filt_level[i]),
      .armed     (armed[i])
    );
  end

`ifndef SYNTHESIS
  always @(clk or n_rst or serial_in) begin
    assert (!$isunknown({clk, n_rst, serial_in, enable, mode}))
      else $warning("start_bit_det_multi: X/Z on clk, n_rst, serial_in, enable or mode");
  end
`endif
endmodule

// File: tb/tb_start_bit_det_multi.sv
module tb_start_bit_det_multi;
  localparam int   NUM_CH      = 4;
  localparam int   SYNC_STAGES = 2;
  localparam int   FILT_LEN    = 3;
  localparam logic IDLE_VAL    = 1'b1;

  logic              clk = 1'b0;
  logic              n_rst = 1'b0;
  logic [NUM_CH-1:0] serial_in = '1;
  logic              enable = 1'b1;
  logic [1:0]        mode = 2'b00;
  logic [NUM_CH-1:0] rearm = '0;
  logic [NUM_CH-1:0] start_bit_detected, filt_level, armed;

  int n_chk = 0;
  int n_fail = 0;
  int obs_cnt [NUM_CH];

  start_bit_det_multi #(
    .NUM_CH(NUM_CH), .SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN), .IDLE_VAL(IDLE_VAL)
  ) dut (
    .clk(clk), .n_rst(n_rst), .serial_in(serial_in), .enable(enable), .mode(mode),
    .rearm(rearm), .start_bit_detected(start_bit_detected), .filt_level(filt_level),
    .armed(armed)
  );

  always #5 clk = ~clk;

  // Behavioural model: a line delay of SYNC_STAGES samples, then a run-length
  // rule on the filtered level, then per-channel armed bits.
  logic [NUM_CH-1:0] m_dly [$];
  logic [NUM_CH-1:0] m_pulse, m_filt, m_armed;
  int                m_run [NUM_CH];

  task automatic model_reset();
    m_dly.delete();
    for (int s = 0; s < SYNC_STAGES; s++) m_dly.push_back({NUM_CH{IDLE_VAL}});
    m_pulse = '0;
    m_filt  = {NUM_CH{IDLE_VAL}};
    m_armed = '1;
    for (int c = 0; c < NUM_CH; c++) m_run[c] = 0;
  endtask

  task automatic model_step();
    logic [NUM_CH-1:0] seen;
    logic fell, qual;
    seen = m_dly.pop_front();
    m_dly.push_back(serial_in);
    m_pulse = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      qual = 1'b0;
      if (enable && seen[c] != m_filt[c]) begin
        m_run[c]++;
        if (m_run[c] >= FILT_LEN) begin
          fell      = m_filt[c];
          m_filt[c] = ~m_filt[c];
          m_run[c]  = 0;
          qual = (mode == 2'd0 && fell) || (mode == 2'd1 && !fell) || (mode == 2'd2);
        end
      end else begin
        m_run[c] = 0;
      end
      if (rearm[c]) m_armed[c] = 1'b1;
      if (qual && m_armed[c]) begin
        m_pulse[c] = 1'b1;
        m_armed[c] = 1'b0;
      end
    end
  endtask

  initial model_reset();

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) model_reset();
    else        model_step();
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Compare process: every cycle against the model.
  always @(negedge clk) begin
    chk("start_bit_detected", 32'(start_bit_detected), 32'(m_pulse));
    chk("filt_level", 32'(filt_level), 32'(m_filt));
    chk("armed", 32'(armed), 32'(m_armed));
    for (int c = 0; c < NUM_CH; c++) if (start_bit_detected[c] === 1'b1) obs_cnt[c]++;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    for (int c = 0; c < NUM_CH; c++) obs_cnt[c] = 0;
    tick(3);
    n_rst = 1'b1;

    // Idle after reset
    tick(20);
    chk("idle_filt", 32'(filt_level), 32'hF);
    chk("idle_armed", 32'(armed), 32'hF);
    chk("idle_pulses", 32'(obs_cnt[0] + obs_cnt[1] + obs_cnt[2] + obs_cnt[3]), 0);

    // Falling edge latency on ch0
    serial_in[0] = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      tick();
      chk($sformatf("latency_E%0d", k), 32'(start_bit_detected), (k == 4) ? 32'h1 : 32'h0);
    end
    chk("lat_armed", 32'(armed), 32'hE);
    chk("lat_filt0", 32'(filt_level[0]), 0);

    // Glitch rejection on ch1: 2 samples rejected, 3 accepted
    serial_in[1] = 1'b0; tick(2); serial_in[1] = 1'b1; tick(8);
    chk("glitch2_filt1", 32'(filt_level[1]), 1);
    chk("glitch2_cnt1", 32'(obs_cnt[1]), 0);
    serial_in[1] = 1'b0; tick(3); serial_in[1] = 1'b1; tick(10);
    chk("glitch3_cnt1", 32'(obs_cnt[1]), 1);

    // Re-arm on ch0
    for (int t = 0; t < 4; t++) begin
      serial_in[0] = t[0] ? 1'b0 : 1'b1;
      tick(6);
    end
    chk("fired_no_pulse", 32'(obs_cnt[0]), 1);
    rearm[0] = 1'b1; tick(); rearm[0] = 1'b0;
    chk("rearm_armed0", 32'(armed[0]), 1);
    serial_in[0] = 1'b1; tick(6);
    serial_in[0] = 1'b0; tick(8);
    chk("rearm_pulse", 32'(obs_cnt[0]), 2);
    serial_in[0] = 1'b1; tick(8);
    serial_in[0] = 1'b0; tick(4);
    rearm[0] = 1'b1; tick(); rearm[0] = 1'b0;
    chk("coinc_pulse", 32'(start_bit_detected[0]), 1);
    chk("coinc_armed", 32'(armed[0]), 0);

    // Modes on ch2
    mode = 2'b01;
    serial_in[2] = 1'b0; tick(8);
    chk("rise_mode_fall", 32'(obs_cnt[2]), 0);
    serial_in[2] = 1'b1; tick(8);
    chk("rise_mode_rise", 32'(obs_cnt[2]), 1);
    mode = 2'b10;
    rearm[2] = 1'b1; tick(); rearm[2] = 1'b0;
    serial_in[2] = 1'b0; tick(8);
    chk("both_fall", 32'(obs_cnt[2]), 2);
    rearm[2] = 1'b1; tick(); rearm[2] = 1'b0;
    serial_in[2] = 1'b1; tick(8);
    chk("both_rise", 32'(obs_cnt[2]), 3);
    mode = 2'b11;
    rearm[2] = 1'b1; tick(); rearm[2] = 1'b0;
    serial_in[2] = 1'b0; tick(8); serial_in[2] = 1'b1; tick(8);
    chk("mode_off", 32'(obs_cnt[2]), 3);
    chk("mode_off_armed", 32'(armed[2]), 1);
    mode = 2'b00; enable = 1'b0;
    serial_in[2] = 1'b0; tick(10);
    chk("disabled_filt", 32'(filt_level[2]), 1);
    serial_in[2] = 1'b1; tick(4); enable = 1'b1; tick(8);
    chk("disabled_cnt", 32'(obs_cnt[2]), 3);

    // Reset mid-filter on ch3
    serial_in[3] = 1'b0; tick(4);
    n_rst = 1'b0; tick(); n_rst = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("rst_mid_R%0d", k), 32'(start_bit_detected[3]), (k == 5) ? 32'h1 : 32'h0);
    end

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 4) == 0) serial_in[c] = ~serial_in[c];
        rearm[c] = ($urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
      if (i % 16 == 0) enable = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 399) == 0) begin
        n_rst = 1'b0; tick(); n_rst = 1'b1;
      end
      tick();
    end
    rearm = '0;
    tick(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
